// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with hold limit driving the 4:1 mux select
module mux_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] others;
    logic [SEL_W-1:0]   pick_idx;
    logic               take;

    // Callers guarantee r is non-zero; the smallest offset from start wins.
    function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [SEL_W-1:0]   start);
        logic [SEL_W-1:0] idx;
        pick = start;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        others   = req & ~gnt_q;
        take     = 1'b0;
        pick_idx = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    take     = 1'b1;
                    pick_idx = pick(req, last_q + SEL_W'(1));
                end
            end
            default: begin
                if (req[sel_q]) begin
                    if (cnt_q != HOLD_LAST) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        // Hold limit reached: yield only if someone else is waiting.
                        cnt_d = '0;
                        if (|others) begin
                            take     = 1'b1;
                            pick_idx = pick(others, sel_q + SEL_W'(1));
                        end
                    end
                end else if (|req) begin
                    take     = 1'b1;
                    pick_idx = pick(req, sel_q + SEL_W'(1));
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase

        if (take) begin
            state_d = ST_GRANT;
            gnt_d   = NUM_REQ'(1) << pick_idx;
            sel_d   = pick_idx;
            last_d  = pick_idx;
            valid_d = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter (MAX_HOLD 4 and 1)
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req0, req1;
    logic [3:0] gnt0, gnt1;
    logic [1:0] sel0, sel1;
    logic       valid0, valid1;
    logic [3:0] mux_in;
    logic       mux_out;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.NUM_REQ(4), .SEL_W(2), .MAX_HOLD(4)) u_hold4 (
        .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .sel(sel0), .valid(valid0)
    );

    mux_rr_arbiter #(.NUM_REQ(4), .SEL_W(2), .MAX_HOLD(1)) u_hold1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1), .sel(sel1), .valid(valid1)
    );

    assign mux_out = mux_in[sel1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
    } vec_t;

    vec_t tbl[13];

    // Reference model: owner (-1 when idle), tenure in cycles, last owner, select.
    int m_owner[2];
    int m_ten[2];
    int m_last[2];
    int m_sel[2];
    int maxh[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ten[d]   = 0;
            m_last[d]  = 3;
            m_sel[d]   = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        logic [3:0] waiting;
        int         nxt;
        waiting = r;
        if (m_owner[d] >= 0) waiting[m_owner[d]] = 1'b0;
        if (m_owner[d] >= 0 && r[m_owner[d]] && (m_ten[d] < maxh[d] || waiting == 4'b0)) begin
            m_ten[d] = (m_ten[d] >= maxh[d]) ? 1 : m_ten[d] + 1;
        end else if (waiting != 4'b0) begin
            nxt = -1;
            for (int i = 1; i <= 4; i++) begin
                if (nxt < 0 && waiting[(m_last[d] + i) % 4]) nxt = (m_last[d] + i) % 4;
            end
            m_owner[d] = nxt;
            m_last[d]  = nxt;
            m_sel[d]   = nxt;
            m_ten[d]   = 1;
        end else begin
            m_owner[d] = -1;
            m_ten[d]   = 0;
        end
    endtask

    task automatic model_check(input int d, input int cyc, input logic [3:0] g,
                               input logic [1:0] s, input logic v);
        logic [3:0] eg;
        eg = (m_owner[d] >= 0) ? (4'b1 << m_owner[d]) : 4'b0;
        chk($sformatf("rand%0d_gnt_c%0d", d, cyc), 32'(g), 32'(eg));
        chk($sformatf("rand%0d_sel_c%0d", d, cyc), 32'(s), 32'(m_sel[d]));
        chk($sformatf("rand%0d_valid_c%0d", d, cyc), 32'(v), 32'(m_owner[d] >= 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r0, r1;
        maxh[0] = 4;
        maxh[1] = 1;
        mux_in  = 4'b1010;
        rst_n   = 1'b1;
        req0    = 4'b0;
        req1    = 4'b0;

        for (int i = 0; i < 6; i++) tbl[i] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
        tbl[11] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{4'b0001, 4'b0001, 2'd0, 1'b1};

        // Reset held across an edge with all requests up.
        @(negedge clk);
        req0  = 4'b1111;
        req1  = 4'b1111;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_sel", 32'(sel0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        rst_n = 1'b1;

        // Full contention: 4-cycle tenures on one instance, per-cycle rotation plus mux on the other.
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("cont_gnt_c%0d", i), 32'(gnt0), 32'(4'b1 << ((i / 4) % 4)));
            chk($sformatf("cont_sel_c%0d", i), 32'(sel0), 32'((i / 4) % 4));
            chk($sformatf("cont_valid_c%0d", i), 32'(valid0), 32'h1);
            chk($sformatf("h1_gnt_c%0d", i), 32'(gnt1), 32'(4'b1 << (i % 4)));
            chk($sformatf("h1_out_c%0d", i), 32'(mux_out), 32'(i % 2));
        end

        // Directed table: single burst, idle sel hold, wrap handover, idle restart.
        req0 = 4'b0;
        req1 = 4'b0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            req0 = tbl[i].req;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl_gnt_%0d", i), 32'(gnt0), 32'(tbl[i].gnt));
            chk($sformatf("tbl_sel_%0d", i), 32'(sel0), 32'(tbl[i].sel));
            chk($sformatf("tbl_valid_%0d", i), 32'(valid0), 32'(tbl[i].valid));
        end

        // Asynchronous reset pulsed between edges while requester 1 owns the mux.
        req0 = 4'b0010;
        do_reset();
        @(posedge clk);
        @(negedge clk);
        chk("ar_pre_gnt", 32'(gnt0), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt0), 32'h0);
        chk("ar_sel", 32'(sel0), 32'h0);
        chk("ar_valid", 32'(valid0), 32'h0);
        req0  = 4'b0110;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ar_post_gnt", 32'(gnt0), 32'h2);
        chk("ar_post_sel", 32'(sel0), 32'h1);

        // Randomized traffic against the reference model.
        req0 = 4'b0;
        req1 = 4'b0;
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            if ($urandom_range(3) == 0) r0 = 4'hF;
            if ($urandom_range(5) == 0) r0 = 4'h0;
            if ($urandom_range(3) == 0) r1 = 4'hF;
            req0 = r0;
            req1 = r1;
            @(posedge clk);
            model_step(0, r0);
            model_step(1, r1);
            @(negedge clk);
            model_check(0, c, gnt0, sel0, valid0);
            model_check(1, c, gnt1, sel1, valid1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 `mux` between four requesters. It accepts a request vector, grants one requester at a time, and drives the mux `sel` input so the granted lane's `in` bit reaches `out`. A hold limit keeps a bursting requester from starving the others. The block sits directly in front of the mux's `sel` port; the mux stays purely combinational.

## Interface
- `NUM_REQ`, 4: number of requesters. Fixed at 4 to match the mux; other values are unsupported.
- `SEL_W`, 2: width of `sel`, equal to log2(`NUM_REQ`).
- `MAX_HOLD`, 4: maximum consecutive cycles one owner keeps the grant while another request is pending. Legal range is 1..15.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `req`  in  4: request vector. Bit i high means requester i wants the mux.
- `gnt`  out  4: registered one-hot grant. It is all-zero when idle.
- `sel`  out  2: registered index of the current or most recent owner. It connects to mux `sel`.
- `valid`  out  1: registered; high when `gnt` is non-zero, meaning mux `out` carries the owner's lane.

## Operation
- Reset values: `gnt`=0000, `sel`=00, `valid`=0, state=IDLE, hold counter=0, last-owner pointer=3 (so the first search starts at requester 0).
- State IDLE:
  - If `req` is zero, remain in IDLE.
  - Otherwise, pick the first set bit of `req`, searching upward from (last+1) mod 4 with wrap-around.
  - Move to GRANT with that owner, clear the counter, and load `sel` with the owner index.
- State GRANT, owner k, evaluated each edge:
  - `req[k]`=1, counter < `MAX_HOLD`-1: keep owner k; counter increments.
  - `req[k]`=1, counter = `MAX_HOLD`-1, another request pending: rotate to the first requester searching from (k+1) mod 4, excluding k; counter clears.
  - `req[k]`=1, counter = `MAX_HOLD`-1, no other request: keep owner k; counter clears. There is no forced release without contention.
  - `req[k]`=0 and other requests pending: hand over directly to the first requester from (k+1) mod 4; counter clears. There is no idle bubble.
  - `req[k]`=0 and `req` all zero: go to IDLE; `gnt` and `valid` clear; `sel` holds k.
- The last-owner pointer updates to the new owner on every grant change.
- `sel` changes only when ownership changes. It never changes in IDLE, so the mux output does not toggle spuriously.
- `MAX_HOLD`=1: under contention, the grant rotates every cycle.
- Counter width is 4 bits. The counter never exceeds `MAX_HOLD`-1.
- A requester that drops `req` while not granted loses nothing. Arbitration uses only the current `req` value; nothing is queued.

## Timing
- Grant latency is one cycle. A `req` sampled high at edge n produces `gnt`/`sel`/`valid` valid after edge n, during cycle n+1.
- Release latency is one cycle. `req[k]` sampled low at edge n means `gnt[k]` is low after edge n.
- The mux `out` for the new owner is valid in the same cycle `valid` rises, because the mux path is combinational from the registered `sel`.
- Handover between two requesters gives back-to-back grants with no zero cycle on `gnt`.
- Reset asserted mid-grant forces all outputs to their reset values asynchronously. After release, arbitration restarts from requester 0.
- Simultaneous requests are resolved only by the round-robin order, never by a fixed priority.

## Test plan
- Reset check: hold `rst_n`=0 with `req`=1111, then release → `gnt`=0001, `sel`=00, `valid`=1 one cycle after the first sampling edge.
- Single requester: `req`=0100 for 6 cycles, then 0000 → `gnt`=0100 and `sel`=10 for the whole burst, with no rotation. After the drop, `gnt`=0000, `valid`=0, and `sel` stays 10.
- Full contention, `MAX_HOLD`=4: hold `req`=1111 → grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; `sel` follows 00, 01, 10, 11.
- Handover with wrap: owner 3, `req` goes from 1000 to 0001 in one cycle → `gnt`=0001 and `sel`=00 on the next cycle, with no zero-`gnt` cycle.
- Datapath: connect to `mux` with `in`=1010 and `req`=1111, `MAX_HOLD`=1 → `out` follows 0, 1, 0, 1 per cycle in step with `sel`.
- Async reset mid-operation: while `gnt`=0010, pulse `rst_n` low between edges → `gnt`=0000, `sel`=00, `valid`=0 immediately. After release with `req`=0110, `gnt`=0010.
